// File: rtl/otter_decode_stage_pipe_if.sv
// IF/ID-to-EX decode bundle: fetch-side inputs, EX-side branch flags, decoded ID/EX outputs.
// The IF/fetch side is the master; the decode stage is the slave.
interface otter_decode_stage_pipe_if #(
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned CNT_W     = 16
);
  logic                 if_valid;
  logic [31:0]          if_instr;
  logic                 ex_br_eq;
  logic                 ex_br_lt;
  logic                 ex_br_ltu;
  logic                 id_stall;
  logic                 flush;
  logic [2:0]           pc_source;
  logic                 ex_valid;
  logic [3:0]           ex_alu_fun;
  logic                 ex_alu_srca;
  logic [1:0]           ex_alu_srcb;
  logic [1:0]           ex_rf_wr_sel;
  logic                 ex_regwrite;
  logic                 ex_memwrite;
  logic                 ex_memread2;
  logic [6:0]           ex_opcode;
  logic [2:0]           ex_func3;
  logic [RF_ADDR_W-1:0] ex_rd;
  logic [RF_ADDR_W-1:0] ex_rs1;
  logic [RF_ADDR_W-1:0] ex_rs2;
  logic                 ex_illegal;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output if_valid, if_instr, ex_br_eq, ex_br_lt, ex_br_ltu,
    input  id_stall, flush, pc_source, ex_valid, ex_alu_fun, ex_alu_srca, ex_alu_srcb,
    input  ex_rf_wr_sel, ex_regwrite, ex_memwrite, ex_memread2, ex_opcode, ex_func3,
    input  ex_rd, ex_rs1, ex_rs2, ex_illegal, bubble_cnt
  );

  modport slave (
    input  if_valid, if_instr, ex_br_eq, ex_br_lt, ex_br_ltu,
    output id_stall, flush, pc_source, ex_valid, ex_alu_fun, ex_alu_srca, ex_alu_srcb,
    output ex_rf_wr_sel, ex_regwrite, ex_memwrite, ex_memread2, ex_opcode, ex_func3,
    output ex_rd, ex_rs1, ex_rs2, ex_illegal, bubble_cnt
  );
endinterface

// File: rtl/otter_decode_stage_pipe.sv
// OTTER pipelined decode stage: decodes IF/ID into the ID/EX register, resolves
// redirects from EX, and inserts one counted bubble per load-use hazard.
module otter_decode_stage_pipe #(
  parameter int unsigned RF_ADDR_W      = 5,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned MRET_EN        = 1,
  parameter int unsigned CNT_W          = 16
) (
  input logic                      clk,
  input logic                      rst,
  otter_decode_stage_pipe_if.slave bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           alu_fun;
    logic                 alu_srca;
    logic [1:0]           alu_srcb;
    logic [1:0]           rf_wr_sel;
    logic                 regwrite;
    logic                 memwrite;
    logic                 memread2;
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic                 illegal;
  } ex_t;

  ex_t              ex_q, ex_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic             f7b5;
  logic             use_rs1, use_rs2;
  logic             hazard, br_taken;
  logic [2:0]       pc_source;
  logic             flush;
  logic             unused_instr;

  assign opcode       = bus.if_instr[6:0];
  assign f3           = bus.if_instr[14:12];
  assign f7b5         = bus.if_instr[30];
  assign unused_instr = ^{bus.if_instr[31], bus.if_instr[29:25]};

  always_comb begin
    dec         = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec.valid   = 1'b1;
    dec.opcode  = opcode;
    dec.func3   = f3;
    dec.rd      = bus.if_instr[7 +: RF_ADDR_W];
    dec.rs1     = bus.if_instr[15 +: RF_ADDR_W];
    dec.rs2     = bus.if_instr[20 +: RF_ADDR_W];
    case (opcode)
      OpLui: begin
        {dec.alu_fun, dec.alu_srca, dec.alu_srcb, dec.rf_wr_sel} = {4'd9, 1'b1, 2'd1, 2'd3};
        dec.regwrite = 1'b1;
      end
      OpAuipc: begin
        {dec.alu_fun, dec.alu_srca, dec.alu_srcb, dec.rf_wr_sel} = {4'd0, 1'b1, 2'd3, 2'd0};
        dec.regwrite = 1'b1;
      end
      OpJal: begin
        dec.alu_srcb = 2'd1;
        dec.regwrite = 1'b1;
      end
      OpJalr: begin
        dec.regwrite = 1'b1;
        use_rs1      = 1'b1;
      end
      OpBranch: begin
        dec.rf_wr_sel = 2'd3;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpLoad: begin
        {dec.alu_srcb, dec.rf_wr_sel} = {2'd1, 2'd2};
        dec.regwrite = 1'b1;
        dec.memread2 = 1'b1;
        use_rs1      = 1'b1;
      end
      OpStore: begin
        {dec.alu_srcb, dec.rf_wr_sel} = {2'd2, 2'd3};
        dec.memwrite = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OpReg: begin
        dec.alu_fun   = {f7b5, f3};
        dec.rf_wr_sel = 2'd3;
        dec.regwrite  = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpImm: begin
        // Only the shift-right encodings carry an f7 qualifier on immediates
        dec.alu_fun   = (f3 == 3'b101) ? {f7b5, f3} : {1'b0, f3};
        dec.alu_srcb  = 2'd1;
        dec.rf_wr_sel = 2'd3;
        dec.regwrite  = 1'b1;
        use_rs1       = 1'b1;
      end
      OpSystem: begin
        {dec.alu_fun, dec.rf_wr_sel} = {4'd9, 2'd1};
        dec.regwrite = 1'b1;
        use_rs1      = ~f3[2];
      end
      default: dec.illegal = 1'b1;
    endcase
    if (!bus.if_valid) begin
      dec = '0;
    end
  end

  always_comb begin
    case (ex_q.func3)
      3'b000:  br_taken = bus.ex_br_eq;
      3'b001:  br_taken = ~bus.ex_br_eq;
      3'b100:  br_taken = bus.ex_br_lt;
      3'b101:  br_taken = ~bus.ex_br_lt;
      3'b110:  br_taken = bus.ex_br_ltu;
      3'b111:  br_taken = ~bus.ex_br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_source = 3'd0;
    if (ex_q.valid) begin
      case (ex_q.opcode)
        OpJal:    pc_source = 3'd3;
        OpJalr:   pc_source = 3'd1;
        OpBranch: pc_source = br_taken ? 3'd2 : 3'd0;
        OpSystem: pc_source = (MRET_EN != 0 && ex_q.func3 == 3'b000) ? 3'd5 : 3'd0;
        default:  pc_source = 3'd0;
      endcase
    end
  end

  assign flush  = (pc_source != 3'd0);
  assign hazard = (LOAD_USE_STALL != 0) && bus.if_valid && ex_q.valid && ex_q.memread2 &&
                  (ex_q.rd != '0) &&
                  ((use_rs1 && ex_q.rd == dec.rs1) || (use_rs2 && ex_q.rd == dec.rs2));

  always_comb begin
    ex_d  = dec;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hazard) begin
      ex_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.id_stall     = hazard & ~flush;
  assign bus.flush        = flush;
  assign bus.pc_source    = pc_source;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_alu_fun   = ex_q.alu_fun;
  assign bus.ex_alu_srca  = ex_q.alu_srca;
  assign bus.ex_alu_srcb  = ex_q.alu_srcb;
  assign bus.ex_rf_wr_sel = ex_q.rf_wr_sel;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_memread2  = ex_q.memread2;
  assign bus.ex_opcode    = ex_q.opcode;
  assign bus.ex_func3     = ex_q.func3;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_illegal   = ex_q.illegal;
  assign bus.bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_otter_decode_stage_pipe.sv
// Bench for otter_decode_stage_pipe: three configurations (default, no mret, 2-bit counter)
// share one stimulus stream and are checked against a per-instance instruction-level model.
module tb_otter_decode_stage_pipe;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_OP = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13, OP_SYS = 7'h73;

  localparam logic [31:0] ADD3  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LW5   = 32'h0000A283;  // lw  x5,0(x1)
  localparam logic [31:0] ADD65 = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] LW0   = 32'h0000A003;  // lw  x0,0(x1)
  localparam logic [31:0] ADD60 = 32'h00200333;  // add x6,x0,x2
  localparam logic [31:0] BEQ   = 32'h00208063;  // beq x1,x2,0
  localparam logic [31:0] JAL1  = 32'h000000EF;  // jal x1,0
  localparam logic [31:0] MRET  = 32'h30200073;
  localparam logic [31:0] ILL   = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  otter_decode_stage_pipe_if #(.RF_ADDR_W(5), .CNT_W(16)) i0 ();
  otter_decode_stage_pipe_if #(.RF_ADDR_W(5), .CNT_W(16)) i1 ();
  otter_decode_stage_pipe_if #(.RF_ADDR_W(5), .CNT_W(2))  i2 ();

  otter_decode_stage_pipe #(.MRET_EN(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
  otter_decode_stage_pipe #(.MRET_EN(0), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(i1));
  otter_decode_stage_pipe #(.MRET_EN(1), .CNT_W(2))  u2 (.clk(clk), .rst(rst), .bus(i2));

  logic [4:0]  o_comb [3];
  logic [13:0] o_ctrl [3];
  logic [24:0] o_fld  [3];
  logic [15:0] o_cnt  [3];

  assign o_comb[0] = {i0.id_stall, i0.flush, i0.pc_source};
  assign o_comb[1] = {i1.id_stall, i1.flush, i1.pc_source};
  assign o_comb[2] = {i2.id_stall, i2.flush, i2.pc_source};
  assign o_ctrl[0] = {i0.ex_valid, i0.ex_alu_fun, i0.ex_alu_srca, i0.ex_alu_srcb,
                      i0.ex_rf_wr_sel, i0.ex_regwrite, i0.ex_memwrite, i0.ex_memread2,
                      i0.ex_illegal};
  assign o_ctrl[1] = {i1.ex_valid, i1.ex_alu_fun, i1.ex_alu_srca, i1.ex_alu_srcb,
                      i1.ex_rf_wr_sel, i1.ex_regwrite, i1.ex_memwrite, i1.ex_memread2,
                      i1.ex_illegal};
  assign o_ctrl[2] = {i2.ex_valid, i2.ex_alu_fun, i2.ex_alu_srca, i2.ex_alu_srcb,
                      i2.ex_rf_wr_sel, i2.ex_regwrite, i2.ex_memwrite, i2.ex_memread2,
                      i2.ex_illegal};
  assign o_fld[0]  = {i0.ex_opcode, i0.ex_func3, i0.ex_rd, i0.ex_rs1, i0.ex_rs2};
  assign o_fld[1]  = {i1.ex_opcode, i1.ex_func3, i1.ex_rd, i1.ex_rs1, i1.ex_rs2};
  assign o_fld[2]  = {i2.ex_opcode, i2.ex_func3, i2.ex_rd, i2.ex_rs1, i2.ex_rs2};
  assign o_cnt[0]  = i0.bubble_cnt;
  assign o_cnt[1]  = i1.bubble_cnt;
  assign o_cnt[2]  = {14'b0, i2.bubble_cnt};

  // Model state: which instruction sits in EX, and the bubble tally, per instance
  logic        m_valid [3];
  logic [31:0] m_instr [3];
  int          m_cnt   [3];
  logic        p_flush [3];
  logic        p_haz   [3];
  logic        p_v;
  logic [31:0] p_ins;
  logic        cur_eq, cur_lt, cur_ltu;

  function automatic int cnt_max(int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic logic [12:0] exp_ctrl(logic [31:0] ins);
    // {alu_fun, srca, srcb, rf_wr_sel, regwrite, memwrite, memread2, illegal}
    case (ins[6:0])
      OP_LUI:   return {4'd9, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_AUIPC: return {4'd0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_JAL:   return {4'd0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_JALR:  return {4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_BR:    return {4'd0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      OP_LOAD:  return {4'd0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      OP_STORE: return {4'd0, 1'b0, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
      OP_OP:    return {ins[30], ins[14:12], 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_IMM:   return {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12],
                        1'b0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_SYS:   return {4'd9, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      default:  return 13'b1;
    endcase
  endfunction

  function automatic bit reads_rs1(logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    return op == OP_OP || op == OP_IMM || op == OP_LOAD || op == OP_STORE || op == OP_BR ||
           op == OP_JALR || (op == OP_SYS && !ins[14]);
  endfunction

  function automatic bit reads_rs2(logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    return op == OP_OP || op == OP_STORE || op == OP_BR;
  endfunction

  function automatic logic [2:0] exp_ps(int k);
    logic [31:0] ins = m_instr[k];
    bit taken;
    if (!m_valid[k]) return 3'd0;
    case (ins[14:12])
      3'b000:  taken = cur_eq;
      3'b001:  taken = !cur_eq;
      3'b100:  taken = cur_lt;
      3'b101:  taken = !cur_lt;
      3'b110:  taken = cur_ltu;
      3'b111:  taken = !cur_ltu;
      default: taken = 0;
    endcase
    if (ins[6:0] == OP_JAL) return 3'd3;
    if (ins[6:0] == OP_JALR) return 3'd1;
    if (ins[6:0] == OP_BR && taken) return 3'd2;
    if (ins[6:0] == OP_SYS && ins[14:12] == 3'b000 && k != 1) return 3'd5;
    return 3'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_check(logic v, logic [31:0] ins, logic eq, logic lt, logic ltu);
    @(negedge clk);
    i0.if_valid = v; i0.if_instr = ins; i0.ex_br_eq = eq; i0.ex_br_lt = lt; i0.ex_br_ltu = ltu;
    i1.if_valid = v; i1.if_instr = ins; i1.ex_br_eq = eq; i1.ex_br_lt = lt; i1.ex_br_ltu = ltu;
    i2.if_valid = v; i2.if_instr = ins; i2.ex_br_eq = eq; i2.ex_br_lt = lt; i2.ex_br_ltu = ltu;
    p_v = v; p_ins = ins; cur_eq = eq; cur_lt = lt; cur_ltu = ltu;
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [2:0]  ps  = exp_ps(k);
      logic [4:0]  ld  = m_instr[k][11:7];
      bit          fl  = (ps != 3'd0);
      bit          hz  = m_valid[k] && m_instr[k][6:0] == OP_LOAD && v && ld != 5'd0 &&
                         ((reads_rs1(ins) && ld == ins[19:15]) ||
                          (reads_rs2(ins) && ld == ins[24:20]));
      p_flush[k] = fl;
      p_haz[k]   = hz;
      chk($sformatf("comb%0d", k), 32'(o_comb[k]), 32'({hz && !fl, fl, ps}));
    end
  endtask

  task automatic clock_check();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (p_flush[k]) begin
        m_valid[k] = 1'b0;
      end else if (p_haz[k]) begin
        m_valid[k] = 1'b0;
        if (m_cnt[k] < cnt_max(k)) m_cnt[k]++;
      end else begin
        m_valid[k] = p_v;
        m_instr[k] = p_ins;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] ins = m_instr[k];
      chk($sformatf("ctrl%0d", k), 32'(o_ctrl[k]),
          m_valid[k] ? 32'({1'b1, exp_ctrl(ins)}) : 32'd0);
      if (m_valid[k])
        chk($sformatf("fields%0d", k), 32'(o_fld[k]),
            32'({ins[6:0], ins[14:12], ins[11:7], ins[19:15], ins[24:20]}));
      chk($sformatf("cnt%0d", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
    end
  endtask

  task automatic step(logic v, logic [31:0] ins, logic eq, logic lt, logic ltu);
    drive_check(v, ins, eq, lt, ltu);
    clock_check();
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      m_instr[k] = 32'd0;
      m_cnt[k]   = 0;
      chk($sformatf("rst_comb%0d", k), 32'(o_comb[k]), 32'd0);
      chk($sformatf("rst_ctrl%0d", k), 32'(o_ctrl[k]), 32'd0);
      chk($sformatf("rst_fld%0d", k), 32'(o_fld[k]), 32'd0);
      chk($sformatf("rst_cnt%0d", k), 32'(o_cnt[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  op;
    case ($urandom_range(13))
      0: op = OP_LUI;   1: op = OP_AUIPC; 2: op = OP_JAL;  3: op = OP_JALR;
      4: op = OP_BR;    5: op = OP_STORE; 6: op = OP_OP;   7: op = OP_IMM;
      8: op = OP_SYS;   9: op = 7'h7F;    10: op = OP_OP;
      default: op = OP_LOAD;
    endcase
    r[6:0]   = op;
    r[11:7]  = 5'($urandom_range(3));
    r[19:15] = 5'($urandom_range(3));
    r[24:20] = 5'($urandom_range(3));
    if (op == OP_SYS && $urandom_range(2) == 0) r = MRET;
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0; m_instr[k] = 32'd0; m_cnt[k] = 0;
    end
    i0.if_valid = 0; i0.if_instr = 0; i0.ex_br_eq = 0; i0.ex_br_lt = 0; i0.ex_br_ltu = 0;
    i1.if_valid = 0; i1.if_instr = 0; i1.ex_br_eq = 0; i1.ex_br_lt = 0; i1.ex_br_ltu = 0;
    i2.if_valid = 0; i2.if_instr = 0; i2.ex_br_eq = 0; i2.ex_br_lt = 0; i2.ex_br_ltu = 0;
    @(negedge clk);
    reset_now();

    step(1, ADD3, 0, 0, 0);
    chk("add_valid", 32'(i0.ex_valid), 32'd1);
    chk("add_alu", 32'(i0.ex_alu_fun), 32'd0);
    chk("add_regwrite", 32'(i0.ex_regwrite), 32'd1);
    chk("add_wrsel", 32'(i0.ex_rf_wr_sel), 32'd3);
    chk("add_rd", 32'(i0.ex_rd), 32'd3);

    step(1, LW5, 0, 0, 0);
    drive_check(1, ADD65, 0, 0, 0);
    chk("lu_stall", 32'(i0.id_stall), 32'd1);
    clock_check();
    chk("lu_bubble", 32'(i0.ex_valid), 32'd0);
    chk("lu_cnt", 32'(i0.bubble_cnt), 32'd1);
    drive_check(1, ADD65, 0, 0, 0);
    chk("lu_one_cycle", 32'(i0.id_stall), 32'd0);
    clock_check();
    chk("lu_add_rd", 32'(i0.ex_rd), 32'd6);

    step(1, LW0, 0, 0, 0);
    drive_check(1, ADD60, 0, 0, 0);
    chk("x0_nostall", 32'(i0.id_stall), 32'd0);
    clock_check();

    step(1, BEQ, 0, 0, 0);
    drive_check(1, ADD3, 1, 0, 0);
    chk("beq_ps", 32'(i0.pc_source), 32'd2);
    chk("beq_flush", 32'(i0.flush), 32'd1);
    clock_check();
    chk("beq_bubble", 32'(i0.ex_valid), 32'd0);
    chk("beq_cnt", 32'(i0.bubble_cnt), 32'd1);
    step(1, BEQ, 0, 0, 0);
    drive_check(1, ADD3, 0, 1, 1);
    chk("beq_nt_ps", 32'(i0.pc_source), 32'd0);
    clock_check();

    step(1, JAL1, 0, 0, 0);
    drive_check(1, ADD65, 0, 0, 0);
    chk("jal_ps", 32'(i0.pc_source), 32'd3);
    chk("jal_stall", 32'(i0.id_stall), 32'd0);
    clock_check();
    chk("jal_cnt", 32'(i0.bubble_cnt), 32'd1);

    step(1, MRET, 0, 0, 0);
    drive_check(1, ADD3, 0, 0, 0);
    chk("mret_ps", 32'(i0.pc_source), 32'd5);
    chk("mret_off_ps", 32'(i1.pc_source), 32'd0);
    clock_check();

    step(1, ILL, 0, 0, 0);
    chk("ill_flag", 32'(i0.ex_illegal), 32'd1);
    chk("ill_en", 32'({i0.ex_regwrite, i0.ex_memwrite, i0.ex_memread2}), 32'd0);

    for (int n = 0; n < 5; n++) begin
      step(1, LW5, 0, 0, 0);
      step(1, ADD65, 0, 0, 0);
    end
    chk("sat_cnt2", 32'(i2.bubble_cnt), 32'd3);
    chk("cnt16", 32'(i0.bubble_cnt), 32'd6);

    step(1, LW5, 0, 0, 0);
    drive_check(1, ADD65, 0, 0, 0);
    #1;
    reset_now();

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(9) != 0), rand_instr(), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
